// File: rtl/huc6280_mmu.sv
// huc6280_mmu: logical-to-physical bus front end for the HuC6280 core.
// Holds MPR0..MPR7 (TAM writes, TMA reads), translates 16-bit CPU requests
// to 21-bit physical accesses and sequences them IDLE->ACC->CAP->[WAIT]->DONE.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   req, rnw, laddr, wdata, csh     CPU request (sampled in IDLE only)
//   ready, rdata, busy              CPU response
//   mpr_we, mpr_sel, mpr_wdata      TAM write (bit mask select)
//   mpr_rd_sel, mpr_rdata           TMA read (combinational OR of selected)
//   addr, dIn, mem_rdata, re, we    physical memory bus
//   CE_n, CER_n                     ROM / RAM chip enables
module huc6280_mmu #(
  parameter int LOW_WAIT = 3,
  parameter int VDC_WAIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic        rnw,
  input  logic [15:0] laddr,
  input  logic [7:0]  wdata,
  input  logic        csh,
  output logic        ready,
  output logic [7:0]  rdata,
  output logic        busy,
  input  logic        mpr_we,
  input  logic [7:0]  mpr_sel,
  input  logic [7:0]  mpr_wdata,
  input  logic [7:0]  mpr_rd_sel,
  output logic [7:0]  mpr_rdata,
  output logic [20:0] addr,
  output logic [7:0]  dIn,
  input  logic [7:0]  mem_rdata,
  output logic        re,
  output logic        we,
  output logic        CE_n,
  output logic        CER_n
);

  typedef enum logic [2:0] {S_IDLE, S_ACC, S_CAP, S_WAIT, S_DONE} state_t;

  state_t          state;
  logic [7:0][7:0] mpr;
  logic [20:0]     phys;
  logic            rnw_q;
  logic            csh_q;
  logic [1:0]      cnt;
  logic [1:0]      wait_n;

  // Translation uses the MPR contents before any same-cycle TAM write.
  assign phys = {mpr[laddr[15:13]], laddr[12:0]};

  always_comb begin
    mpr_rdata = 8'h00;
    for (int i = 0; i < 8; i++)
      if (mpr_rd_sel[i]) mpr_rdata = mpr_rdata | mpr[i];
  end

  // Wait count, evaluated in CAP from the latched address and speed.
  // VDC window is 0x1FE000-0x1FE3FF, i.e. addr[20:10] == 0x7F8.
  always_comb begin
    wait_n = 2'd0;
    if (!csh_q)                   wait_n = 2'(LOW_WAIT);
    else if (addr[20:10] == 11'h7F8) wait_n = 2'(VDC_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mpr <= '0;
    end else if (mpr_we) begin
      for (int i = 0; i < 8; i++)
        if (mpr_sel[i]) mpr[i] <= mpr_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ready <= 1'b0;
      busy  <= 1'b0;
      re    <= 1'b0;
      we    <= 1'b0;
      CE_n  <= 1'b1;
      CER_n <= 1'b1;
      addr  <= '0;
      dIn   <= '0;
      rdata <= '0;
      rnw_q <= 1'b0;
      csh_q <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: if (req) begin
          state <= S_ACC;
          busy  <= 1'b1;
          addr  <= phys;
          dIn   <= wdata;
          rnw_q <= rnw;
          csh_q <= csh;
          re    <= rnw;
          we    <= !rnw;
          // IO space and unmapped gaps leave both enables high.
          CE_n  <= !(phys < 21'h1F0000);
          CER_n <= !(phys[20:13] == 8'hF8);
        end
        S_ACC: begin
          state <= S_CAP;
          re    <= 1'b0;
          we    <= 1'b0;
          CE_n  <= 1'b1;
          CER_n <= 1'b1;
        end
        S_CAP: begin
          if (rnw_q) rdata <= mem_rdata;
          if (wait_n == 2'd0) begin
            state <= S_DONE;
            ready <= 1'b1;
          end else begin
            state <= S_WAIT;
            cnt   <= wait_n;
          end
        end
        S_WAIT: begin
          if (cnt == 2'd1) begin
            state <= S_DONE;
            ready <= 1'b1;
          end
          cnt <= cnt - 2'd1;
        end
        S_DONE: begin
          state <= S_IDLE;
          ready <= 1'b0;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/huc6280_mmu.md
# huc6280_mmu

Logical-to-physical bus front end for the HuC6280 core, directly upstream of the 21-bit physical memory/IO model. It holds the eight mapping registers MPR0–MPR7 written by TAM and read by TMA. It translates each 16-bit CPU request into a 21-bit physical access and sequences the access as strobe, capture and speed-dependent wait cycles. It decodes the ROM and RAM chip enables and returns read data to the core with a single-cycle `ready` handshake.

## Interface
Parameters:
- `LOW_WAIT`, 3: extra wait cycles per access in low-speed mode (csh=0).
- `VDC_WAIT`, 1: extra wait cycles for VDC-region accesses in high-speed mode.

Ports:
- `clk`  in  1  single clock; all state updates on posedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  1  CPU access request; sampled only in IDLE.
- `rnw`  in  1  1=read, 0=write; sampled with `req`.
- `laddr`  in  16  logical address; sampled with `req`.
- `wdata`  in  8  CPU write data; sampled with `req`.
- `csh`  in  1  1=high-speed (7.16 MHz) mode, 0=low-speed; sampled with `req`.
- `ready`  out  1  one-cycle pulse: access complete.
- `rdata`  out  8  read data; valid from `ready` until the next read completes.
- `busy`  out  1  high whenever state≠IDLE.
- `mpr_we`  in  1  TAM write strobe.
- `mpr_sel`  in  8  TAM bit mask; bit i selects MPRi.
- `mpr_wdata`  in  8  TAM data.
- `mpr_rd_sel`  in  8  TMA bit mask.
- `mpr_rdata`  out  8  combinational OR of the selected MPRs; 0x00 if the mask is zero.
- `addr`  out  21  physical address to memory.
- `dIn`  out  8  write data to memory.
- `mem_rdata`  in  8  memory registered read data; valid the cycle after `re`.
- `re`, `we`  out  1  memory strobes; never high together.
- `CE_n`  out  1  ROM enable, low for physical address < 0x1F0000.
- `CER_n`  out  1  RAM enable, low for 0x1F0000–0x1F1FFF.

## Operation
- Translation: phys = {MPR[laddr[15:13]], laddr[12:0]}. The block computes it in IDLE from the current MPR values and latches it with the request.
- Read and write data are latched in the same cycle.
- MPR write: on `mpr_we`, each MPRi with `mpr_sel[i]`=1 takes `mpr_wdata`. Several bits may be set at once.
- An MPR write in the same cycle as an accepted `req` does not affect that request, which uses the old value.
- An MPR write while `busy` is legal and does not alter the latched `addr`.
- The state machine has five states:
  - IDLE: waits for `req`.
  - ACC: one cycle. Drives `addr` and `dIn`, and asserts `re` if `rnw`, otherwise `we`. Drives `CE_n`/`CER_n` per the decode. IO space (≥0x1FE000) and the unmapped gaps leave both enables high.
  - CAP: one cycle. Strobes and enables are deasserted and `addr` is held. On a read, `mem_rdata` is latched into `rdata` at the end of the cycle.
  - WAIT: holds for N cycles. N is `LOW_WAIT` if csh=0. If csh=1, N is `VDC_WAIT` for phys 0x1FE000–0x1FE3FF and 0 otherwise. If N=0 this state is skipped. N is counted by a 2-bit down-counter.
  - DONE: `ready`=1 for one cycle, then IDLE.
- `req` is ignored outside IDLE. A `req` held high through DONE starts a new access in the following IDLE cycle.
- `rdata` is not modified by writes.

## Timing
- Reset values: `ready`=0, `busy`=0, `re`=`we`=0, `CE_n`=`CER_n`=1, `addr`=0, `dIn`=0, `rdata`=0x00, all MPR=0x00, counter=0, state=IDLE.
- All outputs except `mpr_rdata` are registered.
- Cycle numbering starts with the IDLE cycle in which `req` is sampled, cycle 0:
  - Strobes are high in cycle 1.
  - `mem_rdata` is captured at the end of cycle 2.
  - `ready` is high in cycle 3+N.
  - Total latency is 3+N cycles, so 3, 4 or 6 at the default parameters.
- Back-to-back throughput is one access per 4+N cycles, because an IDLE cycle separates accesses.
- Asserting reset mid-access forces the reset values immediately: no `ready` pulse and no further strobes. The next `req` after release is handled normally.

## Test plan
- Reset, then csh=1 read of laddr 0xFFFE → `addr`=0x001FFE, `CE_n`=0 with `re` only in cycle 1, `rdata`=ROM[0x1FFE] with `ready` in cycle 3.
- TAM with sel=0x02 and data 0xF8, then read laddr 0x2030 → `addr`=0x1F0030, `CER_n`=0, `CE_n`=1, `rdata`=RAM[0x30].
- With MPR1=0xF8, write 0x5A to laddr 0x2039 → `we` high one cycle, `re`=0, `ready` in cycle 3. A read of the same address then returns 0x5A.
- Set MPR0=0xFF and read laddr 0x0000 with csh=1 → `addr`=0x1FE000, both enables high, `ready` in cycle 4. The same read with csh=0 → `ready` in cycle 6.
- MPR2=0x11 and MPR5=0x22; `mpr_rd_sel`=0x24 → `mpr_rdata`=0x33. Next, `mpr_we` (sel=0x01, data 0x40) issued in the same cycle as a `req` to laddr 0x0005 → `addr`=0x000005 using the old MPR0. The following request uses 0x40.
- With csh=0, pulse `rst_n` low in WAIT → `busy`, `ready`, `re`, `we` all 0 and `CE_n`=1 immediately, MPRs=0x00. A subsequent read completes normally in 6 cycles.
